// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
//   Shared types and defaults for the wide_add_sequencer slice.
//   Contents:
//     seq_state_t     - sequencer FSM state encoding (IDLE, ADD, DONE)
//     SLICE_W_DEF     - default width of the shared adder, in bits
//     NUM_SLICES_DEF  - default number of slices per operation
//     seq_cnt_w()     - slice counter width for a given slice count
// -----------------------------------------------------------------------------
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int unsigned SLICE_W_DEF    = 8;
  localparam int unsigned NUM_SLICES_DEF = 4;

  // Counter only has to reach NUM_SLICES-1; NUM_SLICES >= 2 keeps this >= 1.
  function automatic int unsigned seq_cnt_w(input int unsigned num_slices);
    return $clog2(num_slices);
  endfunction

endpackage : adder_seq_pkg

// File: rtl/adder_nbit.sv
// -----------------------------------------------------------------------------
// adder_nbit
//   Plain N-bit ripple-carry adder. Purely combinational; this is the only
//   arithmetic in the wide add sequencer, reused once per slice.
//   Ports:
//     a_i    [N-1:0]  operand A slice
//     b_i    [N-1:0]  operand B slice (already inverted by the caller for sub)
//     cin_i           carry in
//     sum_o  [N-1:0]  sum slice
//     ovf_o           carry out of bit N-1
// -----------------------------------------------------------------------------
module adder_nbit #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         ovf_o
);

  logic [N:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < int'(N); i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign ovf_o = carry[N];

endmodule : adder_nbit

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
//   Adds two W-bit operands (W = SLICE_W*NUM_SLICES) by running one shared
//   SLICE_W-bit adder over NUM_SLICES cycles, least-significant slice first,
//   with the carry chained through a register. Trades latency for area.
//
//   Optional feature macro: ADD_SUB_EN
//     defined   -> extra input 'sub'; sub=1 computes A-B mod 2^W
//                  (B inverted, slice-0 carry forced to 1, overflow = no borrow)
//     undefined -> add only, no 'sub' port
//
//   Ports:
//     clk       system clock, rising edge
//     rst       synchronous active-high reset
//     start     request pulse; operands captured on the accepting edge
//     sub       (ADD_SUB_EN only) subtract select, captured with start
//     a_in      [W-1:0] operand A
//     b_in      [W-1:0] operand B
//     carry_in  carry into slice 0
//     busy      high while slices are being added
//     done      one-cycle result-valid pulse
//     sum_out   [W-1:0] result, held until the next completed operation
//     overflow  carry out of the top slice, held with sum_out
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for start
//   ADD   | one slice per cycle through the shared adder, busy=1
//   DONE  | result just published, done=1; start accepted as in IDLE
// -----------------------------------------------------------------------------
module wide_add_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned SLICE_W    = SLICE_W_DEF,
  parameter int unsigned NUM_SLICES = NUM_SLICES_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
`ifdef ADD_SUB_EN
  input  logic                            sub,
`endif
  input  logic [SLICE_W*NUM_SLICES-1:0]   a_in,
  input  logic [SLICE_W*NUM_SLICES-1:0]   b_in,
  input  logic                            carry_in,
  output logic                            busy,
  output logic                            done,
  output logic [SLICE_W*NUM_SLICES-1:0]   sum_out,
  output logic                            overflow
);

  localparam int unsigned W  = SLICE_W * NUM_SLICES;
  localparam int unsigned CW = seq_cnt_w(NUM_SLICES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_SLICES - 1);

  seq_state_t          state_q;
  logic [CW-1:0]       cnt_q;
  logic                carry_q;
  logic [W-1:0]        a_sh_q;
  logic [W-1:0]        b_sh_q;
  logic [W-1:0]        sum_sh_q;
  logic [W-1:0]        sum_sh_d;
  logic [W-1:0]        sum_q;
  logic                ovf_q;
  logic                busy_q;
  logic                done_q;
`ifdef ADD_SUB_EN
  logic                sub_q;
`endif

  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_cout;
  logic                start_carry;

  // Slice operands always come from the low end of the shifting operand regs.
  assign slice_a = a_sh_q[SLICE_W-1:0];
`ifdef ADD_SUB_EN
  assign slice_b     = sub_q ? ~b_sh_q[SLICE_W-1:0] : b_sh_q[SLICE_W-1:0];
  // Two's-complement subtract: the +1 enters as the slice-0 carry.
  assign start_carry = sub ? 1'b1 : carry_in;
`else
  assign slice_b     = b_sh_q[SLICE_W-1:0];
  assign start_carry = carry_in;
`endif

  adder_nbit #(
    .N (SLICE_W)
  ) u_adder (
    .a_i   (slice_a),
    .b_i   (slice_b),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .ovf_o (slice_cout)
  );

  // New slice enters at the MSB end; after NUM_SLICES shifts slice 0 sits at
  // the bottom. Used both for the running shift and the final publish.
  assign sum_sh_d = {slice_sum, sum_sh_q[W-1:SLICE_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            carry_q <= start_carry;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
`ifdef ADD_SUB_EN
            sub_q   <= sub;
`endif
          end else begin
            state_q <= IDLE;
          end
        end

        ADD: begin
          // start is deliberately ignored here; the op in flight runs to end.
          a_sh_q   <= a_sh_q >> SLICE_W;
          b_sh_q   <= b_sh_q >> SLICE_W;
          sum_sh_q <= sum_sh_d;
          carry_q  <= slice_cout;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= sum_sh_d;
            ovf_q   <= slice_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign overflow = ovf_q;

endmodule : wide_add_sequencer

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         overflow;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(
    .SLICE_W    (8),
    .NUM_SLICES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef ADD_SUB_EN
    .sub      (sub),
`endif
    .a_in     (a_in),
    .b_in     (b_in),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Drives a request, then watches negedges until done.
  // lat = negedges from the drive point until done is seen (start accepted on
  // the first posedge, result published NUM_SLICES edges later).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input bit inject,
                        output logic [W-1:0] held, output int lat,
                        output int bcnt, output bit seen);
    a_in = a; b_in = b; carry_in = c; sub = s; start = 1'b1;
    lat = 0; bcnt = 0; seen = 1'b0; held = '0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) held = sum_out;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
      start = inject && (lat <= 3);
      if (start) begin
        a_in = 32'hDEADBEEF; b_in = 32'hCAFEF00D; carry_in = 1'b1; sub = ~s;
      end
    end
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  logic [W-1:0] held;
  int           lat, bcnt, ndone;
  bit           seen;

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0;
    a_in = '0; b_in = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum_out, 0);
    check("rst_ovf",  overflow, 0);

    // rst and start together: rst wins
    a_in = 32'h11111111; b_in = 32'h22222222; start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", busy, 0);

    // 1: carry across slice boundary, latency and busy length
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, held, lat, bcnt, seen);
    check("t1_seen", seen, 1);
    check("t1_lat",  lat, 5);
    check("t1_busy", bcnt, 4);
    check("t1_sum",  sum_out, 32'h00000100);
    check("t1_ovf",  overflow, 0);
    check("t1_busy_done_cycle", busy, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // 2: carry ripples through every slice
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, held, lat, bcnt, seen);
    check("t2_seen", seen, 1);
    check("t2_sum",  sum_out, 32'h00000000);
    check("t2_ovf",  overflow, 1);
    @(negedge clk);

    // 3: carry_in used, then back-to-back start in the DONE cycle
    run_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, 1'b0, held, lat, bcnt, seen);
    check("t3_seen", seen, 1);
    check("t3_sum",  sum_out, 32'h2345678A);
    check("t3_ovf",  overflow, 0);
    check("t3_held_prev", held, 32'h00000000);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, held, lat, bcnt, seen);
    check("t3b_seen", seen, 1);
    check("t3b_lat",  lat, 5);
    check("t3b_held", held, 32'h2345678A);
    check("t3b_sum",  sum_out, 32'hFFFFFFFF);
    check("t3b_ovf",  overflow, 1);
    @(negedge clk);

    // 4: start re-pulsed during the op with other operands is ignored
    run_op(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, 1'b1, held, lat, bcnt, seen);
    check("t4_seen", seen, 1);
    check("t4_lat",  lat, 5);
    check("t4_sum",  sum_out, 32'h10101010);
    check("t4_ovf",  overflow, 0);
    count_dones(10, ndone);
    check("t4_extra_done", ndone, 0);
    check("t4_idle", busy, 0);

    // 5: reset during the 2nd ADD cycle abandons the op
    a_in = 32'h00000001; b_in = 32'h00000001; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_busy_add1", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_sum",  sum_out, 0);
    check("t5_ovf",  overflow, 0);
    count_dones(10, ndone);
    check("t5_no_done", ndone, 0);

`ifdef ADD_SUB_EN
    // 6: subtract
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, held, lat, bcnt, seen);
    check("t6a_seen", seen, 1);
    check("t6a_sum",  sum_out, 32'hFFFFFFFE);
    check("t6a_ovf",  overflow, 0);
    @(negedge clk);
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 1'b0, held, lat, bcnt, seen);
    check("t6b_seen", seen, 1);
    check("t6b_sum",  sum_out, 32'h00000002);
    check("t6b_ovf",  overflow, 1);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_wide_add_sequencer
